// File: rtl/uart_mem_loader_if.sv
// uart_mem_loader_if: byte-in / write-bus bundle for the UART memory loader
//   rx_byte, rx_ready : received byte and its valid level (UART clock domain)
//   wr_en/ch/addr/data: registered write strobe, channel, address and data
//   hold              : console reset request while a frame is in progress
//   done, err         : one-cycle frame-result pulses; err_code holds the last error reason
interface uart_mem_loader_if #(
  parameter int ADDR_W = 16,
  parameter int CH_W = 2
);
  logic [7:0] rx_byte;
  logic rx_ready;
  logic wr_en;
  logic [CH_W-1:0] wr_ch;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0] wr_data;
  logic hold;
  logic done;
  logic err;
  logic [1:0] err_code;
  modport master (
    input rx_byte, rx_ready,
    output wr_en, wr_ch, wr_addr, wr_data, hold, done, err, err_code
  );
  modport slave (
    output rx_byte, rx_ready,
    input wr_en, wr_ch, wr_addr, wr_data, hold, done, err, err_code
  );
endinterface

// File: rtl/uart_mem_loader.sv
// uart_mem_loader: parses sync/channel/address/length/payload/checksum frames into channel writes
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : master side of uart_mem_loader_if (byte input, write bus, frame status)
module uart_mem_loader #(
  parameter int ADDR_W = 16,
  parameter int NUM_CH = 4,
  parameter int CH_W = 2,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int TIMEOUT_CYC = 2000000
) (
  input logic clk,
  input logic rst_n,
  uart_mem_loader_if.master bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, CH, AL, AH, LL, LH, DATA, SUM} state_t;
  state_t st;
  logic s0, s1, s2;
  logic [CH_W-1:0] ch;
  logic [ADDR_W-1:0] addr;
  logic [15:0] len;
  logic [7:0] sum;
  logic [TW-1:0] tcnt;
  logic evt, tout;
  // rx_byte is stable for the whole rx_ready level, so it is taken directly on the event
  assign evt = s1 & ~s2;
  // a byte arriving in the expiry cycle takes priority over the timeout
  assign tout = (st != IDLE) && !evt && (tcnt == TW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s2, s1, s0} <= '0;
      st <= IDLE;
      ch <= '0;
      addr <= '0;
      len <= '0;
      sum <= '0;
      tcnt <= '0;
      bus.wr_en <= 1'b0;
      bus.wr_ch <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.hold <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      bus.err_code <= '0;
    end else begin
      {s2, s1, s0} <= {s1, s0, bus.rx_ready};
      bus.wr_en <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      tcnt <= (evt || st == IDLE) ? '0 : tcnt + TW'(1);
      if (tout) begin
        st <= IDLE;
        bus.hold <= 1'b0;
        bus.err <= 1'b1;
        bus.err_code <= 2'd2;
      end else if (evt) begin
        case (st)
          IDLE: if (bus.rx_byte == SYNC_BYTE) begin
            st <= CH;
            bus.hold <= 1'b1;
            sum <= '0;
          end
          CH: if (32'(bus.rx_byte) >= NUM_CH) begin
            st <= IDLE;
            bus.hold <= 1'b0;
            bus.err <= 1'b1;
            bus.err_code <= 2'd1;
          end else begin
            ch <= CH_W'(bus.rx_byte);
            st <= AL;
          end
          AL: begin
            addr <= ADDR_W'(bus.rx_byte);
            st <= AH;
          end
          AH: begin
            addr <= ADDR_W'({bus.rx_byte, addr[7:0]});
            st <= LL;
          end
          LL: begin
            len <= {8'h00, bus.rx_byte};
            st <= LH;
          end
          LH: begin
            len <= {bus.rx_byte, len[7:0]};
            st <= DATA;
          end
          // length 0 wraps through FFFF, so it naturally runs 2^16 bytes
          DATA: begin
            bus.wr_en <= 1'b1;
            bus.wr_ch <= ch;
            bus.wr_addr <= addr;
            bus.wr_data <= bus.rx_byte;
            addr <= addr + ADDR_W'(1);
            sum <= sum + bus.rx_byte;
            len <= len - 16'd1;
            st <= (len == 16'd1) ? SUM : DATA;
          end
          default: begin
            st <= IDLE;
            bus.hold <= 1'b0;
            bus.done <= (bus.rx_byte == sum);
            bus.err <= (bus.rx_byte != sum);
            bus.err_code <= (bus.rx_byte != sum) ? 2'd3 : bus.err_code;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: scoreboard bench for uart_mem_loader framing, writes, errors and reset
module tb_uart_mem_loader;
  localparam int TO = 1500;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_mem_loader_if #(.ADDR_W(16), .CH_W(2)) bus ();
  uart_mem_loader #(
    .ADDR_W(16), .NUM_CH(4), .CH_W(2), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_rise = 0;
  int n_done = 0;
  int n_err = 0;
  logic [25:0] exp_q[$];
  logic [7:0] pl[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n) begin
    if (bus.wr_en) begin
      chk("wr_latency", 32'(cyc - t_rise), 32'd3);
      chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("wr", {bus.wr_ch, bus.wr_addr, bus.wr_data}, exp_q.pop_front());
    end
    n_done += int'(bus.done);
    n_err += int'(bus.err);
  end
  task automatic send_byte(input logic [7:0] b, input int hi);
    @(negedge clk);
    bus.rx_byte = b;
    bus.rx_ready = 1'b1;
    t_rise = cyc;
    repeat (hi) @(negedge clk);
    bus.rx_ready = 1'b0;
    repeat (4) @(negedge clk);
  endtask
  task automatic send_frame(input logic [1:0] c, input logic [15:0] a, input logic [7:0] bad, input int hi);
    logic [7:0] s;
    s = 8'h00;
    n_done = 0;
    n_err = 0;
    foreach (pl[i]) begin
      exp_q.push_back({c, 16'(a + i), pl[i]});
      s += pl[i];
    end
    send_byte(8'hA5, 4);
    chk("hold_on", 32'(bus.hold), 32'd1);
    send_byte({6'd0, c}, 4);
    send_byte(a[7:0], 4);
    send_byte(a[15:8], 4);
    send_byte(8'(pl.size()), 4);
    send_byte(8'(pl.size() >> 8), 4);
    foreach (pl[i]) send_byte(pl[i], hi);
    send_byte(s + bad, 4);
  endtask
  task automatic expect_end(input string tag, input int d, input int e, input logic [1:0] code);
    repeat (4) @(negedge clk);
    chk({tag, "_done"}, 32'(n_done), 32'(d));
    chk({tag, "_err"}, 32'(n_err), 32'(e));
    chk({tag, "_hold"}, 32'(bus.hold), 32'd0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    if (e != 0) chk({tag, "_code"}, 32'(bus.err_code), 32'(code));
  endtask
  function automatic logic [31:0] outs();
    return {bus.wr_en, bus.wr_ch, bus.wr_addr, bus.wr_data, bus.hold, bus.done, bus.err, bus.err_code};
  endfunction
  initial begin
    int k;
    bus.rx_byte = 8'h00;
    bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 32'd0);
    rst_n = 1'b1;
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(2'd0, 16'h8000, 8'h00, 4);
    expect_end("good", 1, 0, 2'd0);
    send_frame(2'd0, 16'h8000, 8'h01, 4);
    expect_end("badsum", 0, 1, 2'd3);
    n_done = 0;
    n_err = 0;
    send_byte(8'h00, 4);
    send_byte(8'hFF, 4);
    chk("ignore_hold", 32'(bus.hold), 32'd0);
    send_byte(8'hA5, 4);
    chk("sync_hold", 32'(bus.hold), 32'd1);
    send_byte(8'h07, 4);
    expect_end("badch", 0, 1, 2'd1);
    pl = '{8'hAA, 8'hBB};
    send_frame(2'd1, 16'hFFFF, 8'h00, 4);
    expect_end("wrap", 1, 0, 2'd0);
    n_done = 0;
    n_err = 0;
    exp_q.push_back({2'd2, 16'h1000, 8'h11});
    foreach (pl[i]) ;
    send_byte(8'hA5, 4);
    send_byte(8'h02, 4);
    send_byte(8'h00, 4);
    send_byte(8'h10, 4);
    send_byte(8'h03, 4);
    send_byte(8'h00, 4);
    send_byte(8'h11, 4);
    k = 0;
    while (n_err == 0 && k < TO + 100) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_window", 32'(k > TO - 20 && k < TO + 20), 32'd1);
    expect_end("timeout", 0, 1, 2'd2);
    pl = '{8'h01, 8'h02};
    send_frame(2'd2, 16'h0040, 8'h00, 4);
    expect_end("after_to", 1, 0, 2'd0);
    pl = '{8'h5A};
    send_frame(2'd3, 16'h0123, 8'h00, 1000);
    expect_end("held", 1, 0, 2'd0);
    n_done = 0;
    n_err = 0;
    exp_q.push_back({2'd0, 16'h0200, 8'h01});
    exp_q.push_back({2'd0, 16'h0200 + 16'd1, 8'h02});
    send_byte(8'hA5, 4);
    send_byte(8'h00, 4);
    send_byte(8'h00, 4);
    send_byte(8'h02, 4);
    send_byte(8'h04, 4);
    send_byte(8'h00, 4);
    send_byte(8'h01, 4);
    send_byte(8'h02, 4);
    chk("mid_hold", 32'(bus.hold), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_outs", outs(), 32'd0);
    chk("rst_pending", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_no_pulse", 32'(n_done + n_err), 32'd0);
    pl = '{8'h09, 8'h08, 8'h07};
    send_frame(2'd1, 16'h0300, 8'h00, 4);
    expect_end("post_rst", 1, 0, 2'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
